// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, one-deep request tracking, stale-response
// dropping after a redirect, and a small FIFO of fetched instructions for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic [31:0] bp_pc,
  input  logic        bp_predicted_outcome,
  input  logic [31:0] bp_predicted_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_target
);

  // DEPTH is 2..4, so two pointer bits and a 3-bit count always suffice
  localparam int unsigned PtrW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CntW = 3;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  typedef enum logic [0:0] {StFetch, StDrop} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     redir_pc_q, redir_pc_d;  // PC to resume at once the stale response lands
  logic            outst_q, outst_d;        // request issued but not yet accepted
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0] instr_mem  [DEPTH];
  logic [31:0] pc_mem     [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [31:0] target_mem [DEPTH];

  logic accept;
  logic push;
  logic pop;

  // State register and datapath flops
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      redir_pc_q <= RESET_PC;
      outst_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redir_pc_q <= redir_pc_d;
      outst_q    <= outst_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage; entries are only visible while counted valid
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_mem[wr_ptr_q]  <= imem_rdata;
      pc_mem[wr_ptr_q]     <= pc_q;
      taken_mem[wr_ptr_q]  <= bp_predicted_outcome;
      target_mem[wr_ptr_q] <= bp_predicted_target;
    end
  end

  // Output decode: request generation and buffer head presentation
  always_comb begin
    bp_pc     = pc_q;
    imem_addr = pc_q;
    // Reset forces the request low even though the flops already hold their idle values
    imem_req  = nRST && ((state_q == StDrop) || outst_q || (count_q < CntW'(DEPTH)));
    out_valid = (count_q != '0);
    if (out_valid) begin
      out_instr       = instr_mem[rd_ptr_q];
      out_pc          = pc_mem[rd_ptr_q];
      out_pred_taken  = taken_mem[rd_ptr_q];
      out_pred_target = target_mem[rd_ptr_q];
    end else begin
      out_instr       = '0;
      out_pc          = '0;
      out_pred_taken  = 1'b0;
      out_pred_target = '0;
    end
  end

  // Next-state: FSM, PC selection and FIFO bookkeeping
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redir_pc_d = redir_pc_q;
    accept     = imem_req && imem_ready;
    outst_d    = imem_req && !imem_ready;
    push       = 1'b0;
    pop        = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    unique case (state_q)
      StFetch: begin
        if (redirect) begin
          if (imem_req && !imem_ready) begin
            // Keep presenting the old address until memory takes it
            state_d    = StDrop;
            redir_pc_d = redirect_pc;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (accept) begin
          push = 1'b1;
          pc_d = bp_predicted_outcome ? bp_predicted_target : pc_q + 32'd4;
        end
      end
      StDrop: begin
        if (redirect) begin
          redir_pc_d = redirect_pc;
        end
        if (imem_ready) begin
          state_d = StFetch;
          pc_d    = redirect ? redirect_pc : redir_pc_q;
        end
      end
      default: state_d = StFetch;
    endcase

    pop = out_valid && out_ready && !redirect;

    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with DEPTH=2 and RESET_PC=0.
module tb_fetch_stage;

  logic        CLK;
  logic        nRST;
  logic [31:0] bp_pc;
  logic        bp_predicted_outcome;
  logic [31:0] bp_predicted_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_pred_taken;
  logic [31:0] out_pred_target;

  logic        bp_force;
  logic [31:0] bp_force_tgt;

  int errors = 0;
  int checks = 0;

  // Memory returns a word derived from its address; predictor is not-taken unless forced
  assign imem_rdata           = imem_addr ^ 32'hCAFE_0000;
  assign bp_predicted_outcome = bp_force;
  assign bp_predicted_target  = bp_force ? bp_force_tgt : bp_pc + 32'd4;

  fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .CLK                 (CLK),
    .nRST                (nRST),
    .bp_pc               (bp_pc),
    .bp_predicted_outcome(bp_predicted_outcome),
    .bp_predicted_target (bp_predicted_target),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_ready          (imem_ready),
    .imem_rdata          (imem_rdata),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_instr           (out_instr),
    .out_pc              (out_pc),
    .out_pred_taken      (out_pred_taken),
    .out_pred_target     (out_pred_target)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST         = 1'b0;
    imem_ready   = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    out_ready    = 1'b0;
    bp_force     = 1'b0;
    bp_force_tgt = '0;
    tick();
    tick();
    nRST = 1'b1;
    #1;
  endtask

  // Land on a chosen PC by redirecting in the same cycle as the first response
  task automatic jump_to(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    imem_ready  = 1'b1;
    tick();
    redirect    = 1'b0;
    imem_ready  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    nRST = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req got=%0b exp=0", imem_req);
    end
    checks++;
    if (out_valid !== 1'b0 || out_pred_taken !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%0b/%0b exp=0/0", out_valid, out_pred_taken);
    end
    checks++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0 || out_pred_target !== 32'h0) begin
      errors++;
      $display("FAIL reset_out got=%h/%h/%h exp=0/0/0", out_pc, out_instr, out_pred_target);
    end
    checks++;
    if (imem_addr !== 32'h0 || bp_pc !== 32'h0) begin
      errors++; $display("FAIL reset_pc got=%h/%h exp=0/0", imem_addr, bp_pc);
    end
    nRST = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req got=%0b@%h exp=1@00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    imem_ready = 1'b1;
    out_ready  = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hCAFE_0000) begin
      errors++;
      $display("FAIL seq_0 got=%0b pc=%h instr=%h exp=1 pc=0 instr=cafe0000",
               out_valid, out_pc, out_instr);
    end
    checks++;
    if (imem_addr !== 32'h4) begin
      errors++; $display("FAIL seq_addr got=%h exp=00000004", imem_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4) begin
      errors++; $display("FAIL seq_4 got=%0b pc=%h exp=1 pc=4", out_valid, out_pc);
    end
    tick();
    checks++;
    if (out_pc !== 32'h8 || out_instr !== 32'hCAFE_0008) begin
      errors++; $display("FAIL seq_8 got=%h/%h exp=8/cafe0008", out_pc, out_instr);
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_taken();
    do_reset();
    jump_to(32'h10);
    checks++;
    if (bp_pc !== 32'h10 || out_valid !== 1'b0) begin
      errors++; $display("FAIL taken_setup got=%h/%0b exp=10/0", bp_pc, out_valid);
    end
    bp_force     = 1'b1;
    bp_force_tgt = 32'h08;
    imem_ready   = 1'b1;
    tick();
    bp_force   = 1'b0;
    imem_ready = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'h08) begin
      errors++; $display("FAIL taken_addr got=%h exp=00000008", imem_addr);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_pred_taken !== 1'b1 ||
        out_pred_target !== 32'h08) begin
      errors++;
      $display("FAIL taken_entry got=%0b pc=%h t=%0b tgt=%h exp=1 pc=10 t=1 tgt=8",
               out_valid, out_pc, out_pred_taken, out_pred_target);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_ready = 1'b1;
    out_ready  = 1'b0;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0 || out_pc !== 32'h0 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL bp_full got=%0b pc=%h addr=%h exp=0 pc=0 addr=8", imem_req, out_pc, imem_addr);
    end
    tick();
    checks++;
    if (imem_req !== 1'b0 || out_pc !== 32'h0) begin
      errors++; $display("FAIL bp_hold got=%0b pc=%h exp=0 pc=0", imem_req, out_pc);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || out_pc !== 32'h4) begin
      errors++;
      $display("FAIL bp_resume got=%0b addr=%h pc=%h exp=1 addr=8 pc=4", imem_req, imem_addr, out_pc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h8) begin
      errors++; $display("FAIL bp_next got=%0b pc=%h exp=1 pc=8", out_valid, out_pc);
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_redirect_in_flight(input logic reredirect);
    logic [31:0] exp_pc;
    exp_pc = reredirect ? 32'h180 : 32'h100;
    do_reset();
    out_ready = 1'b1;
    jump_to(32'h20);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_hold got=%0b addr=%h v=%0b exp=1 addr=20 v=0", imem_req, imem_addr, out_valid);
    end
    if (reredirect) begin
      redirect    = 1'b1;
      redirect_pc = 32'h180;
    end
    tick();
    redirect = 1'b0;
    tick();
    checks++;
    if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin
      errors++; $display("FAIL drop_stable got=%0b addr=%h exp=1 addr=20", imem_req, imem_addr);
    end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== exp_pc || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL drop_done got=v%0b addr=%h req=%0b exp=v0 addr=%h req=1",
               out_valid, imem_addr, imem_req, exp_pc);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    out_ready = 1'b0;
    jump_to(32'h2C);
    imem_ready = 1'b1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    imem_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL same_flush got=v%0b addr=%h req=%0b exp=v0 addr=40 req=1",
               out_valid, imem_addr, imem_req);
    end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    #1;
    checks++;
    if (out_pc !== 32'h40 || out_instr !== 32'hCAFE_0040) begin
      errors++; $display("FAIL same_next got=%h/%h exp=40/cafe0040", out_pc, out_instr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    jump_to(32'hFFFF_FFFC);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'h0 || out_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap got=%h/%h exp=0/fffffffc", imem_addr, out_pc);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    jump_to(32'h20);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL abort got=%0b v=%0b addr=%h exp=0 v=0 addr=0", imem_req, out_valid, imem_addr);
    end
    imem_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_nopush got=%0b exp=0", out_valid);
    end
    nRST = 1'b1;
    #1;
    tick();
    imem_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL abort_restart got=%0b pc=%h addr=%h exp=1 pc=0 addr=4", out_valid, out_pc, imem_addr);
    end
  endtask

  initial begin
    nRST         = 1'b0;
    imem_ready   = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    out_ready    = 1'b0;
    bp_force     = 1'b0;
    bp_force_tgt = '0;
    #1;
    test_reset();
    test_sequential();
    test_taken();
    test_backpressure();
    test_redirect_in_flight(1'b0);
    test_redirect_in_flight(1'b1);
    test_same_cycle();
    test_wrap();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
